ysyx_23060208_ifu: RTL

Instruction fetch unit of the multi-cycle ysyx_23060208 core. It holds the architectural PC and fetches one 32-bit instruction per round over an AXI4 read master port to instruction SRAM. It hands `{pc, inst}` to the IDU with a valid/allowin handshake, then waits for the EXU's next-PC bus before starting the next fetch. One instruction is in flight at a time.

---
 rtl/ysyx_23060208_ifu_pkg.sv | 16 +
 rtl/ysyx_23060208_ifu.sv | 107 ++++++++++
 2 files changed

// File: rtl/ysyx_23060208_ifu_pkg.sv
// Shared definitions for the ysyx_23060208 IFU: bus widths, FSM state encodings and reset PC.
package ysyx_23060208_ifu_pkg;

   localparam int          IFU_TO_IDU_BUS = 64;
   localparam int          EXU_TO_IFU_BUS = 33;
   localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;

   typedef enum logic [2:0] {
      FETCH_AR = 3'd0,
      FETCH_R  = 3'd1,
      HOLD     = 3'd2,
      WAIT_EXU = 3'd3,
      FAULT    = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ysyx_23060208_ifu.sv
// Instruction fetch unit: one AXI4 single-beat read per instruction, handoff to IDU, wait for EXU next-PC.
// Optional YSYX_IFU_RRESP_CHECK_EN traps on a non-OKAY read response into a sticky FAULT state.
module ysyx_23060208_ifu
   import ysyx_23060208_ifu_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [EXU_TO_IFU_BUS-1:0] exu_to_ifu_bus,
   input  logic                      exu_to_ifu_valid,
   output logic                      isram_arvalid,
   input  logic                      isram_arready,
   output logic [DATA_WIDTH-1:0]     isram_araddr,
   output logic [3:0]                isram_arid,
   output logic [7:0]                isram_arlen,
   output logic [2:0]                isram_arsize,
   output logic [1:0]                isram_arburst,
   input  logic                      isram_rvalid,
   output logic                      isram_rready,
   input  logic [63:0]               isram_rdata,
   input  logic [1:0]                isram_rresp,
   input  logic                      isram_rlast,
   input  logic [3:0]                isram_rid,
   output logic [IFU_TO_IDU_BUS-1:0] ifu_to_idu_bus,
   output logic                      ifu_to_idu_valid,
   input  logic                      idu_allowin,
`ifdef YSYX_IFU_RRESP_CHECK_EN
   output logic                      ifu_fault,
`endif
   output logic                      ifu_done
);

   ifu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] inst_q, inst_d;
   logic                  run_q, run_d;
   logic                  nextpc_taken;
   logic [DATA_WIDTH-1:0] nextpc;
   logic                  unused_inputs;

   assign nextpc_taken  = exu_to_ifu_bus[32];
   assign nextpc        = exu_to_ifu_bus[31:0];
   assign unused_inputs = ^{isram_rlast, isram_rid, isram_rresp};

   // run_q keeps arvalid low during reset and raises it on the first edge after release
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FETCH_AR;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      run_d   = 1'b1;
      case (state_q)
         FETCH_AR: if (isram_arvalid && isram_arready) state_d = FETCH_R;
         FETCH_R: begin
            if (isram_rvalid) begin
               inst_d  = pc_q[2] ? isram_rdata[63:32] : isram_rdata[31:0];
`ifdef YSYX_IFU_RRESP_CHECK_EN
               state_d = (isram_rresp != 2'b00) ? FAULT : HOLD;
`else
               state_d = HOLD;
`endif
            end
         end
         HOLD:     if (idu_allowin) state_d = WAIT_EXU;
         WAIT_EXU: begin
            if (exu_to_ifu_valid) begin
               pc_d    = nextpc_taken ? nextpc : pc_q + DATA_WIDTH'(4);
               state_d = FETCH_AR;
            end
         end
`ifdef YSYX_IFU_RRESP_CHECK_EN
         FAULT:    state_d = FAULT;
`endif
         default:  state_d = FETCH_AR;
      endcase
   end

   assign isram_arvalid    = run_q && (state_q == FETCH_AR);
   assign isram_araddr     = pc_q;
   assign isram_arid       = 4'd0;
   assign isram_arlen      = 8'd0;
   assign isram_arsize     = 3'b010;
   assign isram_arburst    = 2'b01;
   assign isram_rready     = (state_q == FETCH_R);
   assign ifu_done         = isram_rready && isram_rvalid;
   assign ifu_to_idu_valid = (state_q == HOLD);
   assign ifu_to_idu_bus   = {pc_q, inst_q};
`ifdef YSYX_IFU_RRESP_CHECK_EN
   assign ifu_fault        = (state_q == FAULT);
`endif

endmodule
